// File: rtl/id_fetch_buffer_pkg.sv
// id_fetch_buffer_pkg: shared constants and entry types for the instruction fetch buffer
package id_fetch_buffer_pkg;
    localparam logic [31:0] NOP_INST = 32'h00000013;
    typedef enum logic [1:0] {IB_FREE, IB_PEND, IB_FULL} ibuf_state_t;
    typedef struct packed {
        ibuf_state_t state;
        logic [31:0] pc;
        logic [31:0] inst;
    } ibuf_entry_t;
endpackage

// File: rtl/id_fetch_buffer_if.sv
// id_fetch_buffer_if: fetch request, imem response, flush and decode handshake bundle; master = fetch/imem/decode side, slave = buffer
interface id_fetch_buffer_if #(
    parameter int DEPTH = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic req_valid;
    logic [ADDR_W-1:0] req_pc;
    logic req_ready;
    logic imem_resp;
    logic [DATA_W-1:0] imem_rdata;
    logic flush;
    logic dec_valid;
    logic dec_ready;
    logic [DATA_W-1:0] dec_inst;
    logic [ADDR_W-1:0] dec_pc;
    logic [63:0] dec_order;
    logic [$clog2(DEPTH+1)-1:0] count;
    modport master (
        output req_valid, req_pc, imem_resp, imem_rdata, flush, dec_ready,
        input req_ready, dec_valid, dec_inst, dec_pc, dec_order, count
    );
    modport slave (
        input req_valid, req_pc, imem_resp, imem_rdata, flush, dec_ready,
        output req_ready, dec_valid, dec_inst, dec_pc, dec_order, count
    );
endinterface

// File: rtl/id_fetch_buffer.sv
// id_fetch_buffer: DEPTH-entry in-order instruction queue between imem and decode; ports clk, rst_n (async active-low), bus (slave: request, imem response, flush, decode handshake, count)
module id_fetch_buffer
    import id_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input logic clk,
    input logic rst_n,
    id_fetch_buffer_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    ibuf_state_t st_q [DEPTH];
    ibuf_state_t st_d [DEPTH];
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [ADDR_W-1:0] pc_d [DEPTH];
    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [DATA_W-1:0] inst_d [DEPTH];
    logic [PW-1:0] alloc_q, alloc_d, fill_q, fill_d, head_q, head_d, used, pend;
    logic [CW-1:0] drop_q, drop_d;
    logic [63:0] order_q, order_d;
    logic dec_valid_q, dec_valid_d;
    logic [DATA_W-1:0] dec_inst_q, dec_inst_d;
    logic [ADDR_W-1:0] dec_pc_q, dec_pc_d;
    logic acc, drain, drop_hit, fill_hit;

    assign used = alloc_q - head_q;
    assign pend = alloc_q - fill_q;
    assign bus.req_ready = (used < PW'(DEPTH)) && !bus.flush;
    assign acc = bus.req_valid && bus.req_ready;
    assign drain = dec_valid_q && bus.dec_ready;
    assign drop_hit = bus.imem_resp && (drop_q != '0);
    assign fill_hit = bus.imem_resp && (drop_q == '0) && (pend != '0);

    always_comb begin
        st_d = st_q;
        pc_d = pc_q;
        inst_d = inst_q;
        alloc_d = alloc_q + PW'(acc);
        fill_d = fill_q + PW'(fill_hit);
        head_d = head_q + PW'(drain);
        drop_d = drop_q - CW'(drop_hit);
        order_d = order_q + 64'(drain);
        if (acc) begin
            st_d[alloc_q[IW-1:0]] = IB_PEND;
            pc_d[alloc_q[IW-1:0]] = bus.req_pc;
        end
        if (fill_hit) begin
            st_d[fill_q[IW-1:0]] = IB_FULL;
            inst_d[fill_q[IW-1:0]] = bus.imem_rdata;
        end
        if (drain)
            st_d[head_q[IW-1:0]] = IB_FREE;
        // a response landing on a pending entry in the flush cycle is already consumed, so only the rest are owed
        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++)
                st_d[i] = IB_FREE;
            fill_d = alloc_q;
            head_d = alloc_q;
            drop_d = drop_d + CW'(pend - PW'(fill_hit));
        end
        dec_valid_d = st_d[head_d[IW-1:0]] == IB_FULL;
        dec_inst_d = dec_valid_d ? inst_d[head_d[IW-1:0]] : DATA_W'(NOP_INST);
        dec_pc_d = dec_valid_d ? pc_d[head_d[IW-1:0]] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i] <= IB_FREE;
                pc_q[i] <= '0;
                inst_q[i] <= '0;
            end
            alloc_q <= '0;
            fill_q <= '0;
            head_q <= '0;
            drop_q <= '0;
            order_q <= '0;
            dec_valid_q <= 1'b0;
            dec_inst_q <= DATA_W'(NOP_INST);
            dec_pc_q <= '0;
        end else begin
            st_q <= st_d;
            pc_q <= pc_d;
            inst_q <= inst_d;
            alloc_q <= alloc_d;
            fill_q <= fill_d;
            head_q <= head_d;
            drop_q <= drop_d;
            order_q <= order_d;
            dec_valid_q <= dec_valid_d;
            dec_inst_q <= dec_inst_d;
            dec_pc_q <= dec_pc_d;
        end
    end

    assign bus.dec_valid = dec_valid_q;
    assign bus.dec_inst = dec_inst_q;
    assign bus.dec_pc = dec_pc_q;
    assign bus.dec_order = order_q;
    assign bus.count = CW'(used);

    // a response with nothing outstanding is a memory-side protocol error
    assert property (@(posedge clk) disable iff (!rst_n) bus.imem_resp |-> (drop_q != '0 || pend != '0));
endmodule

// File: tb/tb_id_fetch_buffer.sv
// tb_id_fetch_buffer: randomized and directed checks of id_fetch_buffer against a queue-based reference model
module tb_id_fetch_buffer;
    localparam int DEPTH = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int VW = 1 + DATA_W + ADDR_W + 64 + CW + 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit full;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_fetch_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    id_fetch_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    ent_t mq[$];
    logic [31:0] mem_q[$];
    logic [31:0] seen[$];
    int m_drop;
    logic [63:0] m_order;
    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] inst_of(logic [31:0] pc);
        return 32'h00100093 + (pc << 5);
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic v;
        logic [31:0] i, p;
        v = 1'b0;
        i = 32'h13;
        p = 32'h0;
        if (mq.size() > 0)
            if (mq[0].full) begin
                v = 1'b1;
                i = mq[0].inst;
                p = mq[0].pc;
            end
        return {v, i, p, m_order, CW'(mq.size()), mq.size() < DEPTH};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.dec_valid, bus.dec_inst, bus.dec_pc, bus.dec_order, bus.count, bus.req_ready};
    endfunction

    task automatic model_reset();
        mq.delete();
        mem_q.delete();
        seen.delete();
        m_drop = 0;
        m_order = '0;
    endtask

    // one clock: drive inputs, advance the reference model across the edge, idle inputs, return at negedge
    task automatic cyc(input bit rv, input logic [31:0] pc, input bit resp, input bit fl, input bit dr);
        bit acc, drain, done;
        logic [31:0] rpc;
        ent_t e;
        rv = rv && (mem_q.size() < DEPTH);
        resp = resp && (mem_q.size() > 0);
        bus.req_valid = rv;
        bus.req_pc = pc;
        bus.imem_resp = resp;
        bus.imem_rdata = 32'hDEADBEEF;
        if (resp) bus.imem_rdata = inst_of(mem_q[0]);
        bus.flush = fl;
        bus.dec_ready = dr;
        drain = 1'b0;
        if (mq.size() > 0) drain = mq[0].full && dr;
        acc = rv && (mq.size() < DEPTH) && !fl;
        if (bus.dec_valid && dr) seen.push_back(bus.dec_pc);
        @(posedge clk);
        if (resp) begin
            rpc = mem_q.pop_front();
            done = 1'b0;
            if (m_drop > 0) m_drop--;
            else foreach (mq[k])
                if (!done && !mq[k].full) begin
                    mq[k].full = 1'b1;
                    mq[k].inst = inst_of(rpc);
                    done = 1'b1;
                end
        end
        if (drain) begin
            e = mq.pop_front();
            m_order = m_order + 64'd1;
        end
        if (acc) begin
            e.pc = pc;
            e.inst = 32'h0;
            e.full = 1'b0;
            mq.push_back(e);
            mem_q.push_back(pc);
        end
        if (fl) begin
            foreach (mq[k]) if (!mq[k].full) m_drop++;
            mq.delete();
        end
        #1;
        bus.req_valid = 1'b0;
        bus.imem_resp = 1'b0;
        bus.flush = 1'b0;
        bus.dec_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [VW-1:0] want;
        want = {1'b0, 32'h13, 32'h0, 64'h0, CW'(0), 1'b1};
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (obs_vec() !== want) begin
            fails++;
            $display("FAIL reset: got %h want %h", obs_vec(), want);
        end
    endtask

    task automatic test_streaming(input logic [31:0] base);
        bit ok;
        logic [63:0] o0;
        seen.delete();
        o0 = m_order;
        for (int c = 0; c < 8; c++) begin
            cyc(c < 4, base + 32'(c * 4), 1'b1, 1'b0, 1'b1);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL stream[%0d]: got %h want %h", c, obs_vec(), exp_vec());
            end
            tests++;
            if (bus.count > CW'(2)) begin
                fails++;
                $display("FAIL stream_count[%0d]: got %0d want <=2", c, bus.count);
            end
        end
        ok = seen.size() == 4;
        for (int i = 0; i < 4 && ok; i++) ok = seen[i] == base + 32'(i * 4);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stream_order: got %0d handshakes want 4 in PC order", seen.size());
        end
        tests++;
        if (bus.dec_order !== o0 + 64'd4) begin
            fails++;
            $display("FAIL stream_tag: got %0d want %0d", bus.dec_order, o0 + 64'd4);
        end
    endtask

    task automatic test_full_stall();
        for (int c = 0; c < 8; c++) begin
            cyc(c < 4, 32'h200 + 32'(c * 4), 1'b1, 1'b0, 1'b0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL full[%0d]: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        tests++;
        if ({bus.req_ready, bus.count, bus.dec_valid, bus.dec_inst} !== {1'b0, CW'(4), 1'b1, inst_of(32'h200)}) begin
            fails++;
            $display("FAIL full_state: got rdy=%b cnt=%0d inst=%h want rdy=0 cnt=4 inst=%h",
                     bus.req_ready, bus.count, bus.dec_inst, inst_of(32'h200));
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tests++;
        if ({bus.req_ready, bus.count} !== {1'b1, CW'(3)}) begin
            fails++;
            $display("FAIL full_release: got rdy=%b cnt=%0d want rdy=1 cnt=3", bus.req_ready, bus.count);
        end
        for (int c = 0; c < 4; c++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL full_drain[%0d]: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_flush();
        logic [35:0] s [9];
        logic [63:0] o0;
        s = '{{1'b1, 32'h300, 3'b000}, {1'b1, 32'h304, 3'b100}, {1'b1, 32'h308, 3'b000},
              {1'b0, 32'h0, 3'b010}, {1'b1, 32'h100, 3'b100}, {1'b0, 32'h0, 3'b100},
              {1'b0, 32'h0, 3'b100}, {1'b0, 32'h0, 3'b001}, {1'b0, 32'h0, 3'b001}};
        o0 = m_order;
        for (int c = 0; c < 9; c++) begin
            cyc(s[c][35], s[c][34:3], s[c][2], s[c][1], s[c][0]);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL flush[%0d]: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 3) begin
                tests++;
                if ({bus.dec_valid, bus.dec_inst, bus.count, bus.req_ready} !== {1'b0, 32'h13, CW'(0), 1'b1}) begin
                    fails++;
                    $display("FAIL flush_clear: got v=%b inst=%h cnt=%0d rdy=%b want v=0 inst=13 cnt=0 rdy=1",
                             bus.dec_valid, bus.dec_inst, bus.count, bus.req_ready);
                end
            end
            if (c == 6) begin
                tests++;
                if ({bus.dec_valid, bus.dec_pc, bus.dec_order} !== {1'b1, 32'h100, o0}) begin
                    fails++;
                    $display("FAIL flush_refetch: got v=%b pc=%h ord=%0d want v=1 pc=100 ord=%0d",
                             bus.dec_valid, bus.dec_pc, bus.dec_order, o0);
                end
            end
        end
    endtask

    task automatic test_flush_collide();
        logic [35:0] s [7];
        logic [63:0] o0;
        bit bad;
        s = '{{1'b1, 32'h400, 3'b000}, {1'b1, 32'h404, 3'b100}, {1'b1, 32'h408, 3'b000},
              {1'b0, 32'h0, 3'b111}, {1'b1, 32'h500, 3'b101}, {1'b0, 32'h0, 3'b101},
              {1'b0, 32'h0, 3'b001}};
        seen.delete();
        o0 = m_order;
        for (int c = 0; c < 7; c++) begin
            cyc(s[c][35], s[c][34:3], s[c][2], s[c][1], s[c][0]);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL collide[%0d]: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 3) begin
                tests++;
                if ({bus.dec_order, bus.count, bus.dec_valid} !== {o0 + 64'd1, CW'(0), 1'b0}) begin
                    fails++;
                    $display("FAIL collide_order: got ord=%0d cnt=%0d v=%b want ord=%0d cnt=0 v=0",
                             bus.dec_order, bus.count, bus.dec_valid, o0 + 64'd1);
                end
            end
            if (c == 5) begin
                tests++;
                if ({bus.dec_valid, bus.dec_pc} !== {1'b1, 32'h500}) begin
                    fails++;
                    $display("FAIL collide_next: got v=%b pc=%h want v=1 pc=500", bus.dec_valid, bus.dec_pc);
                end
            end
        end
        bad = 1'b0;
        foreach (seen[k]) if (seen[k] == 32'h404 || seen[k] == 32'h408) bad = 1'b1;
        tests++;
        if (bad || seen.size() != 2) begin
            fails++;
            $display("FAIL collide_dropped: got %0d handshakes (stale=%b) want 2 (stale=0)", seen.size(), bad);
        end
    endtask

    task automatic test_wrap();
        localparam int N = 3 * DEPTH + 1;
        int issued;
        bit go, ok;
        logic [63:0] o0;
        seen.delete();
        issued = 0;
        o0 = m_order;
        for (int c = 0; c < 400 && seen.size() < N; c++) begin
            go = (issued < N) && (mq.size() < DEPTH) && (mem_q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            cyc(go, 32'h1000 + 32'(issued * 4), $urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 2) != 0);
            issued += int'(go);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL wrap[%0d]: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        ok = seen.size() == N;
        for (int i = 0; i < N && ok; i++) ok = seen[i] == 32'h1000 + 32'(i * 4);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL wrap_delivery: got %0d in-order handshakes want %0d", seen.size(), N);
        end
        tests++;
        if (bus.dec_order !== o0 + 64'(N)) begin
            fails++;
            $display("FAIL wrap_tag: got %0d want %0d", bus.dec_order, o0 + 64'(N));
        end
    endtask

    task automatic test_async_reset();
        logic [VW-1:0] want;
        want = {1'b0, 32'h13, 32'h0, 64'h0, CW'(0), 1'b1};
        cyc(1'b1, 32'h600, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h604, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (obs_vec() !== want) begin
            fails++;
            $display("FAIL async_reset: got %h want %h", obs_vec(), want);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_streaming(32'h700);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_pc = '0;
        bus.imem_resp = 1'b0;
        bus.imem_rdata = '0;
        bus.flush = 1'b0;
        bus.dec_ready = 1'b0;
        test_reset();
        test_streaming(32'h0);
        test_full_stall();
        test_flush();
        test_flush_collide();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
